// File: rtl/addr_xlate_unit.sv
// Two-stage VA->PA translator feeding TLB search port 1: st1 holds the request, rsp_* holds the result.
// Optional direct-map windows are enabled with `define MMU_DMW_EN.
module addr_xlate_unit #(
  parameter int TLBIDX_W = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_va,
  input  logic [1:0]          req_type,
  input  logic                csr_crmd_da,
  input  logic                csr_crmd_pg,
  input  logic [1:0]          csr_crmd_plv,
  input  logic [1:0]          csr_crmd_datm,
  input  logic [9:0]          csr_asid,
  input  logic [31:0]         csr_dmw0,
  input  logic [31:0]         csr_dmw1,
  output logic [18:0]         s_vppn,
  output logic                s_va_bit12,
  output logic [9:0]          s_asid,
  input  logic                s_found,
  input  logic [TLBIDX_W-1:0] s_index,
  input  logic [19:0]         s_ppn,
  input  logic [5:0]          s_ps,
  input  logic [1:0]          s_plv,
  input  logic [1:0]          s_mat,
  input  logic                s_d,
  input  logic                s_v,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_pa,
  output logic [1:0]          rsp_mat,
  output logic [2:0]          rsp_exc
);

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_TLBR = 3'd1;
  localparam logic [2:0] EXC_PIL  = 3'd2;
  localparam logic [2:0] EXC_PIS  = 3'd3;
  localparam logic [2:0] EXC_PIF  = 3'd4;
  localparam logic [2:0] EXC_PME  = 3'd5;
  localparam logic [2:0] EXC_PPI  = 3'd6;

  logic        st1_valid;
  logic [31:0] st1_va;
  logic [1:0]  st1_type;
  logic        advance;
  logic        accept;
  logic [31:0] x_pa;
  logic [1:0]  x_mat;
  logic [2:0]  x_exc;
  logic        unused_inputs;

  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = !flush && (!st1_valid || advance);
  assign accept    = req_valid && req_ready;

  assign s_vppn     = st1_va[31:13];
  assign s_va_bit12 = st1_va[12];
  assign s_asid     = csr_asid;

  // TLB index is only meaningful to TLBSRCH; window CSRs are partly or wholly ignored.
  assign unused_inputs = ^{s_index, csr_dmw0, csr_dmw1};

`ifdef MMU_DMW_EN
  logic dmw0_hit;
  logic dmw1_hit;
  assign dmw0_hit = csr_dmw0[csr_crmd_plv] && (st1_va[31:29] == csr_dmw0[31:29]);
  assign dmw1_hit = csr_dmw1[csr_crmd_plv] && (st1_va[31:29] == csr_dmw1[31:29]);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st1_valid <= 1'b0;
      st1_va    <= '0;
      st1_type  <= '0;
    end else if (flush) begin
      st1_valid <= 1'b0;
    end else if (accept) begin
      st1_valid <= 1'b1;
      st1_va    <= req_va;
      st1_type  <= req_type;
    end else if (advance) begin
      st1_valid <= 1'b0;
    end
  end

  // Illegal mode (da=0, pg=0) falls back to direct addressing.
  always_comb begin
    x_pa  = '0;
    x_mat = '0;
    x_exc = EXC_NONE;
    if (csr_crmd_da || !csr_crmd_pg) begin
      x_pa  = st1_va;
      x_mat = csr_crmd_datm;
    end
`ifdef MMU_DMW_EN
    else if (dmw0_hit) begin
      x_pa  = {csr_dmw0[27:25], st1_va[28:0]};
      x_mat = csr_dmw0[5:4];
    end else if (dmw1_hit) begin
      x_pa  = {csr_dmw1[27:25], st1_va[28:0]};
      x_mat = csr_dmw1[5:4];
    end
`endif
    else begin
      x_mat = s_mat;
      if (!s_found) begin
        x_exc = EXC_TLBR;
        x_mat = '0;
      end else if (!s_v) begin
        case (st1_type)
          2'd0:    x_exc = EXC_PIF;
          2'd2:    x_exc = EXC_PIS;
          default: x_exc = EXC_PIL;
        endcase
      end else if (csr_crmd_plv > s_plv) begin
        x_exc = EXC_PPI;
      end else if ((st1_type == 2'd2) && !s_d) begin
        x_exc = EXC_PME;
      end else if (s_ps == 6'd22) begin
        x_pa = {s_ppn[19:10], st1_va[21:0]};
      end else begin
        x_pa = {s_ppn, st1_va[11:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_pa    <= '0;
      rsp_mat   <= '0;
      rsp_exc   <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (st1_valid && advance) begin
      rsp_valid <= 1'b1;
      rsp_pa    <= x_pa;
      rsp_mat   <= x_mat;
      rsp_exc   <= x_exc;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addr_xlate_unit.sv
// Directed bench for addr_xlate_unit: a translation model predicts every response in order,
// and literal expectations pin the model on the documented example vectors.
module tb_addr_xlate_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_va;
  logic [1:0]  req_type;
  logic        csr_crmd_da;
  logic        csr_crmd_pg;
  logic [1:0]  csr_crmd_plv;
  logic [1:0]  csr_crmd_datm;
  logic [9:0]  csr_asid;
  logic [31:0] csr_dmw0;
  logic [31:0] csr_dmw1;
  logic [18:0] s_vppn;
  logic        s_va_bit12;
  logic [9:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic [19:0] s_ppn;
  logic [5:0]  s_ps;
  logic [1:0]  s_plv;
  logic [1:0]  s_mat;
  logic        s_d;
  logic        s_v;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_pa;
  logic [1:0]  rsp_mat;
  logic [2:0]  rsp_exc;

  int n_checks = 0;
  int n_pass   = 0;
  int rsp_seen = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  addr_xlate_unit #(.TLBIDX_W(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_type(req_type),
    .csr_crmd_da(csr_crmd_da), .csr_crmd_pg(csr_crmd_pg), .csr_crmd_plv(csr_crmd_plv),
    .csr_crmd_datm(csr_crmd_datm), .csr_asid(csr_asid), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv),
    .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pa(rsp_pa), .rsp_mat(rsp_mat),
    .rsp_exc(rsp_exc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // Translation rules from the current CSR/TLB stimulus; result packed as {exc, mat, pa}.
  function automatic logic [36:0] model_xlate(input logic [31:0] va, input logic [1:0] ty);
    logic [31:0] dmw;
    logic [31:0] ppn;
    logic [2:0]  inv_exc;
    if (csr_crmd_da || !csr_crmd_pg) return {3'd0, csr_crmd_datm, va};
`ifdef MMU_DMW_EN
    for (int w = 0; w < 2; w++) begin
      dmw = (w == 0) ? csr_dmw0 : csr_dmw1;
      if (dmw[csr_crmd_plv] && dmw[31:29] == va[31:29])
        return {3'd0, dmw[5:4], dmw[27:25], va[28:0]};
    end
`endif
    if (!s_found) return {3'd1, 2'd0, 32'd0};
    inv_exc = (ty == 2'd0) ? 3'd4 : (ty == 2'd2) ? 3'd3 : 3'd2;
    if (!s_v) return {inv_exc, s_mat, 32'd0};
    if (csr_crmd_plv > s_plv) return {3'd6, s_mat, 32'd0};
    if (ty == 2'd2 && !s_d) return {3'd5, s_mat, 32'd0};
    ppn = {12'd0, s_ppn};
    if (s_ps == 6'd22) return {3'd0, s_mat, ((ppn >> 10) << 22) | (va & 32'h003F_FFFF)};
    return {3'd0, s_mat, (ppn << 12) | (va & 32'h0000_0FFF)};
  endfunction

  // In-order scoreboard: every valid response cycle is compared, so stalls must hold data stable.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!resetn) exp_q.delete();
    else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        else begin
          e = exp_q[0];
          chk("mon_pa", rsp_pa, e[31:0]);
          chk("mon_mat", {30'd0, rsp_mat}, {30'd0, e[33:32]});
          chk("mon_exc", {29'd0, rsp_exc}, {29'd0, e[36:34]});
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_seen++;
          end
        end
      end
      if (flush) exp_q.delete();
      else if (req_valid && req_ready) exp_q.push_back(model_xlate(req_va, req_type));
    end
  end

  // Presents a request and returns just after the edge that accepted it.
  task automatic send_req(input logic [31:0] va, input logic [1:0] ty);
    logic acc;
    int   n;
    req_valid = 1'b1;
    req_va    = va;
    req_type  = ty;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_one(input string nm, input logic [31:0] va, input logic [1:0] ty,
                            input logic [31:0] epa, input logic [1:0] emat, input logic [2:0] eexc);
    int lat;
    rsp_ready = 1'b1;
    send_req(va, ty);
    req_valid = 1'b0;
    chk({nm, "_vppn"}, {13'd0, s_vppn}, {13'd0, va[31:13]});
    chk({nm, "_b12"}, {31'd0, s_va_bit12}, {31'd0, va[12]});
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, 32'd1);
    chk({nm, "_pa"}, rsp_pa, epa);
    chk({nm, "_mat"}, {30'd0, rsp_mat}, {30'd0, emat});
    chk({nm, "_exc"}, {29'd0, rsp_exc}, {29'd0, eexc});
    @(posedge clk);
    #1;
  endtask

  task automatic tlb_set(input logic found, input logic [19:0] ppn, input logic [5:0] ps,
                         input logic [1:0] plv, input logic [1:0] mat, input logic d, input logic v);
    s_found = found; s_ppn = ppn; s_ps = ps; s_plv = plv; s_mat = mat; s_d = d; s_v = v;
  endtask

  task automatic quiet_cycles(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk(nm, {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    int w;
    int seen0;
    resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_va = '0; req_type = '0;
    csr_crmd_da = 1'b1; csr_crmd_pg = 1'b0; csr_crmd_plv = 2'd0; csr_crmd_datm = 2'd0;
    csr_asid = 10'h155; csr_dmw0 = '0; csr_dmw1 = '0; s_index = '0; rsp_ready = 1'b1;
    tlb_set(1'b0, 20'd0, 6'd12, 2'd0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_pa", rsp_pa, 32'd0);
    chk("rst_mat_exc", {27'd0, rsp_mat, rsp_exc}, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("s_asid", {22'd0, s_asid}, 32'h155);

    csr_crmd_datm = 2'd1;
    expect_one("da_load", 32'h1C00_0040, 2'd1, 32'h1C00_0040, 2'd1, 3'd0);
    csr_crmd_da = 1'b0; csr_crmd_datm = 2'd2;
    expect_one("illegal_mode", 32'h8765_4321, 2'd2, 32'h8765_4321, 2'd2, 3'd0);

    csr_crmd_pg = 1'b1; csr_dmw0 = 32'h9000_0011;
    tlb_set(1'b1, 20'h12345, 6'd12, 2'd0, 2'd2, 1'b1, 1'b1);
`ifdef MMU_DMW_EN
    expect_one("dmw0", 32'h9000_1234, 2'd1, 32'h1000_1234, 2'd1, 3'd0);
    csr_dmw1 = 32'h8A00_0021;
    expect_one("dmw0_wins", 32'h9000_1234, 2'd1, 32'h1000_1234, 2'd1, 3'd0);
    csr_dmw0 = '0;
    expect_one("dmw1", 32'h9000_1234, 2'd1, 32'hB000_1234, 2'd2, 3'd0);
`else
    expect_one("dmw_off", 32'h9000_1234, 2'd1, 32'h1234_5234, 2'd2, 3'd0);
`endif
    csr_dmw0 = '0; csr_dmw1 = '0;

    tlb_set(1'b1, 20'h12345, 6'd12, 2'd0, 2'd1, 1'b0, 1'b1);
    expect_one("pme_store", 32'h0000_5678, 2'd2, 32'h0, 2'd1, 3'd5);
    expect_one("hit_load", 32'h0000_5678, 2'd1, 32'h1234_5678, 2'd1, 3'd0);
    expect_one("rsv_type", 32'h0000_5678, 2'd3, 32'h1234_5678, 2'd1, 3'd0);
    tlb_set(1'b1, 20'hABCDE, 6'd22, 2'd0, 2'd3, 1'b1, 1'b1);
    expect_one("ps22", 32'h0012_3456, 2'd1, 32'hABD2_3456, 2'd3, 3'd0);
    tlb_set(1'b0, 20'h12345, 6'd12, 2'd0, 2'd1, 1'b1, 1'b1);
    expect_one("tlbr_fetch", 32'h0000_5678, 2'd0, 32'h0, 2'd0, 3'd1);
    tlb_set(1'b1, 20'h12345, 6'd12, 2'd0, 2'd1, 1'b1, 1'b0);
    expect_one("pis_store", 32'h0000_5678, 2'd2, 32'h0, 2'd1, 3'd3);
    expect_one("pif_fetch", 32'h0000_5678, 2'd0, 32'h0, 2'd1, 3'd4);
    tlb_set(1'b1, 20'h12345, 6'd12, 2'd0, 2'd1, 1'b0, 1'b1);
    csr_crmd_plv = 2'd3;
    expect_one("ppi", 32'h0000_5678, 2'd2, 32'h0, 2'd1, 3'd6);
    csr_crmd_plv = 2'd0;

    // Four back-to-back loads against a stalled consumer.
    tlb_set(1'b1, 20'h00ABC, 6'd12, 2'd0, 2'd3, 1'b1, 1'b1);
    seen0 = rsp_seen;
    rsp_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send_req(32'h0000_1000 * k + 32'h10 * k + 32'h3, 2'd1);
        req_valid = 1'b0;
      end
      begin
        w = 0;
        while (!rsp_valid && w < 20) begin
          @(posedge clk);
          #1;
          w++;
        end
        chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    w = 0;
    while ((exp_q.size() != 0 || rsp_valid) && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("stall_count", rsp_seen - seen0, 32'd4);

    // Flush with st1 and rsp both occupied.
    rsp_ready = 1'b0;
    send_req(32'h0000_2001, 2'd1);
    send_req(32'h0000_3002, 2'd1);
    req_va = 32'h0000_4003;
    rsp_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    quiet_cycles("flush_st1_killed", 3);

    // Asynchronous reset pulse mid-stream.
    rsp_ready = 1'b0;
    send_req(32'h0000_5004, 2'd1);
    send_req(32'h0000_6005, 2'd1);
    req_valid = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_pa", rsp_pa, 32'd0);
    chk("arst_mat_exc", {27'd0, rsp_mat, rsp_exc}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rsp_ready = 1'b1;
    quiet_cycles("arst_st1_cleared", 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
